// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the zero-register address and the address type
// used by the reg_file block and its read ports.
`default_nettype none

package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/reg_file_if.sv
// reg_file_if: read/write/debug bus of the architectural register file.
// master = processor datapath (or bench), slave = reg_file.
`default_nettype none

interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output raddr1, raddr2, we, waddr, wdata, dbg_addr,
        input  rdata1, rdata2, dbg_data
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, dbg_addr,
        output rdata1, rdata2, dbg_data
    );
endinterface : reg_file_if

`default_nettype wire

// File: rtl/regfile_rport.sv
// regfile_rport: one combinational read port with register-0 zero check.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to this port.
`default_nettype none

module regfile_rport
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  wire logic [2**ADDR_W-1:0][DATA_W-1:0] file_i,
    input  wire logic [ADDR_W-1:0]                raddr_i,
    input  wire logic                             byp_en_i,
    input  wire logic [ADDR_W-1:0]                waddr_i,
    input  wire logic [DATA_W-1:0]                wdata_i,
    output logic      [DATA_W-1:0]                rdata_o
);

    always_comb begin
        rdata_o = '0;
        if (raddr_i != ADDR_W'(REG_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
            if (byp_en_i && (raddr_i == waddr_i)) begin
                rdata_o = wdata_i;
            end else begin
                rdata_o = file_i[raddr_i];
            end
`else
            rdata_o = file_i[raddr_i];
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only matter when forwarding is built in.
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_en_i, waddr_i, wdata_i};
`endif

endmodule : regfile_rport

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: 32x32 architectural register file, 2 combinational read ports,
// 1 write port, r0 hardwired to zero. Optional macro: REGFILE_BYPASS_EN.
`default_nettype none

module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    reg_file_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_W;

    // Only registers 1..DEPTH-1 are stored; r0 is spliced in as a constant.
    logic [DEPTH-1:1][DATA_W-1:0] regs_q;
    logic [DEPTH-1:1][DATA_W-1:0] regs_d;
    logic [DEPTH-1:0][DATA_W-1:0] w_file;
    logic                         w_wr_en;
    logic                         w_byp_en;

    assign w_wr_en  = bus.we && (bus.waddr != ADDR_W'(REG_ZERO));
    // A write that reset discards must not be forwarded either.
    assign w_byp_en = w_wr_en && rst_n;

    always_comb begin
        regs_d = regs_q;
        if (w_wr_en) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign w_file = {regs_q, {DATA_W{1'b0}}};

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport1 (
        .file_i   (w_file),
        .raddr_i  (bus.raddr1),
        .byp_en_i (w_byp_en),
        .waddr_i  (bus.waddr),
        .wdata_i  (bus.wdata),
        .rdata_o  (bus.rdata1)
    );

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport2 (
        .file_i   (w_file),
        .raddr_i  (bus.raddr2),
        .byp_en_i (w_byp_en),
        .waddr_i  (bus.waddr),
        .wdata_i  (bus.wdata),
        .rdata_o  (bus.rdata2)
    );

    always_comb begin
        bus.dbg_data = '0;
        if (bus.dbg_addr != ADDR_W'(REG_ZERO)) begin
            bus.dbg_data = w_file[bus.dbg_addr];
        end
    end

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized + directed bench for reg_file; an array model
// produces expected reads into a queue, a negedge monitor pops and compares.
`default_nettype none

module tb_reg_file;
    import regfile_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
    } exp_t;

    logic clk;
    logic rst_n;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] model [32];
    exp_t        expq [$];
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rd(input reg_addr_t a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && bus.we && (bus.waddr != 5'd0) && (a == bus.waddr)) return bus.wdata;
`endif
        return model[a];
    endfunction

    function automatic logic [31:0] ref_dbg(input reg_addr_t a);
        if (a == 5'd0) return 32'd0;
        return model[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle of stimulus: retire the previous cycle's write into the
    // model at the edge, then drive new inputs and queue the expected reads.
    task automatic cyc(input string nm, input logic rst, input logic w,
                       input reg_addr_t wa, input logic [31:0] wd,
                       input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t da);
        exp_t e;
        @(posedge clk);
        if (rst_n && bus.we && (bus.waddr != 5'd0)) model[bus.waddr] = bus.wdata;
        #1;
        rst_n        = rst;
        bus.we       = w;
        bus.waddr    = wa;
        bus.wdata    = wd;
        bus.raddr1   = a1;
        bus.raddr2   = a2;
        bus.dbg_addr = da;
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end
        e.name = nm;
        e.r1   = ref_rd(a1);
        e.r2   = ref_rd(a2);
        e.dbg  = ref_dbg(da);
        expq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk({e.name, ".rdata1"},   bus.rdata1,   e.r1);
                chk({e.name, ".rdata2"},   bus.rdata2,   e.r2);
                chk({e.name, ".dbg_data"}, bus.dbg_data, e.dbg);
            end
        end
    end

    initial begin : stim
        reg_addr_t a1;
        reg_addr_t wa;
        logic      w;
        logic      r;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst_n        = 1'b0;
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
        bus.dbg_addr = '0;

        cyc("reset",      1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 5'd31);
        cyc("release",    1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 5'd31);
        cyc("wr9",        1'b1, 1'b1, 5'd9, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        cyc("rd9",        1'b1, 1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 5'd9);
        cyc("wr0",        1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        cyc("rd0",        1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0);
        cyc("we_low",     1'b1, 1'b0, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3);
        cyc("rd3",        1'b1, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 5'd3);
        cyc("wr5_old",    1'b1, 1'b1, 5'd5, 32'h11112222, 5'd0, 5'd0, 5'd0);
        cyc("rdw5_pre",   1'b1, 1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, 5'd5);
        cyc("rdw5_post",  1'b1, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5);

        for (int i = 1; i < 32; i++)
            cyc("sweep_wr", 1'b1, 1'b1, 5'(i), i * 32'h01010101, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++)
            cyc("sweep_rd", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));

        cyc("rst_async",  1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 5'd31);
        cyc("rst_midwr",  1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7);
        cyc("rst_rel",    1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 5'd7);
        cyc("first_wr",   1'b1, 1'b1, 5'd7, 32'h0BADC0DE, 5'd0, 5'd0, 5'd0);
        cyc("first_rd",   1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd7);

        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) != 0);
            w  = $urandom_range(0, 1) != 0;
            wa = 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            cyc("random", r, w, wa, $urandom, a1, 5'($urandom), 5'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
